// File: rtl/esm_pkg.sv
// Shared definitions for the ESM slot allocator.
// Provides the default buffer depth, the matching index/count widths and typedefs for the
// default configuration.
package esm_pkg;

  localparam int unsigned EsmBs     = 16;
  localparam int unsigned EsmBsBits = $clog2(EsmBs);

  // Slot index and free-count types for the default depth.
  typedef logic [EsmBsBits-1:0] esm_idx_t;
  typedef logic [EsmBsBits:0]   esm_cnt_t;

endpackage

// File: rtl/esm_free_fifo.sv
// Circular FIFO of free slot indices.
// On reset or flush the storage is loaded with the identity sequence 0..Bs-1 and the FIFO is
// full. One push and one pop may occur in the same cycle; the caller guarantees no pop when
// empty and no push when full.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   flush_i           synchronous reload of the reset contents (overrides push/pop)
//   push_i/push_idx_i append an index at the tail
//   pop_i             advance the head
//   head_idx_o        index at the head
//   count_o           number of indices held, 0..Bs
module esm_free_fifo
  import esm_pkg::*;
#(
  parameter int unsigned Bs = EsmBs,
  localparam int unsigned BsBits = $clog2(Bs)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [BsBits-1:0] push_idx_i,
  input  logic              pop_i,
  output logic [BsBits-1:0] head_idx_o,
  output logic [BsBits:0]   count_o
);

  logic [BsBits-1:0] fifo_q [Bs];
  logic [BsBits-1:0] fifo_d [Bs];
  logic [BsBits-1:0] head_q, head_d;
  logic [BsBits-1:0] tail_q, tail_d;
  logic [BsBits:0]   count_q, count_d;

  always_comb begin
    fifo_d  = fifo_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      for (int i = 0; i < Bs; i++) begin
        fifo_d[i] = BsBits'(i);
      end
      head_d  = '0;
      tail_d  = '0;
      count_d = (BsBits + 1)'(Bs);
    end else begin
      if (push_i) begin
        fifo_d[tail_q] = push_idx_i;
        tail_d         = tail_q + 1'b1;
      end
      if (pop_i) begin
        head_d = head_q + 1'b1;
      end
      unique case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Bs; i++) begin
        fifo_q[i] <= BsBits'(i);
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= (BsBits + 1)'(Bs);
    end else begin
      fifo_q  <= fifo_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_idx_o = fifo_q[head_q];
  assign count_o    = count_q;

endmodule

// File: rtl/esm_slot_allocator.sv
// ESM buffer slot allocator: grants free slot indices to dispatch and reclaims slots released
// by the issue side. Free slots are kept in FIFO order; an occupancy bitmap validates releases.
// Optional feature: ESM_ALLOC_BYPASS_EN - when the free list is empty, a legal release is
// offered combinationally as the grant in the same cycle (handed straight over if
// alloc_valid_i is high).
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   alloc_valid_i                dispatch requests a slot
//   alloc_ready_o/alloc_index_o  a slot is free / index of that slot
//   rel_valid_i/rel_index_i      issue side returns a slot
//   flush_i                      return every slot to the free list
//   free_count_o                 free slots, 0..bs
//   occupied_o                   per-slot allocated flags
//   rel_err_o                    one-cycle pulse after an illegal release
module esm_slot_allocator
  import esm_pkg::*;
#(
  parameter int unsigned bs = EsmBs,
  localparam int unsigned bs_bits = $clog2(bs)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               alloc_valid_i,
  output logic               alloc_ready_o,
  output logic [bs_bits-1:0] alloc_index_o,
  input  logic               rel_valid_i,
  input  logic [bs_bits-1:0] rel_index_i,
  input  logic               flush_i,
  output logic [bs_bits:0]   free_count_o,
  output logic [bs-1:0]      occupied_o,
  output logic               rel_err_o
);

  logic [bs-1:0]      occupied_q, occupied_d;
  logic               rel_err_q, rel_err_d;
  logic [bs_bits-1:0] head_idx;
  logic [bs_bits:0]   count;
  logic               empty;
  logic               rel_legal;
  logic               bypass_avail;
  logic               handover;
  logic               push;
  logic               pop;

  assign empty     = (count == '0);
  // A slot being granted this cycle is not yet occupied, so releasing it is illegal.
  assign rel_legal = rel_valid_i & occupied_q[rel_index_i];

`ifdef ESM_ALLOC_BYPASS_EN
  assign bypass_avail = empty & rel_legal;
  assign handover     = bypass_avail & alloc_valid_i;
`else
  assign bypass_avail = 1'b0;
  assign handover     = 1'b0;
`endif

  assign alloc_ready_o = ~empty | bypass_avail;
  assign alloc_index_o = bypass_avail ? rel_index_i : head_idx;

  // A handed-over slot never touches the FIFO and stays occupied.
  assign pop  = alloc_valid_i & ~empty & ~flush_i;
  assign push = rel_legal & ~handover & ~flush_i;

  always_comb begin
    occupied_d = occupied_q;
    rel_err_d  = 1'b0;
    if (flush_i) begin
      occupied_d = '0;
    end else begin
      if (pop) begin
        occupied_d[head_idx] = 1'b1;
      end
      if (push) begin
        occupied_d[rel_index_i] = 1'b0;
      end
      rel_err_d = rel_valid_i & ~rel_legal;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occupied_q <= '0;
      rel_err_q  <= 1'b0;
    end else begin
      occupied_q <= occupied_d;
      rel_err_q  <= rel_err_d;
    end
  end

  esm_free_fifo #(
    .Bs (bs)
  ) u_free_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .push_i     (push),
    .push_idx_i (rel_index_i),
    .pop_i      (pop),
    .head_idx_o (head_idx),
    .count_o    (count)
  );

  assign free_count_o = count;
  assign occupied_o   = occupied_q;
  assign rel_err_o    = rel_err_q;

endmodule

// File: tb/tb_esm_slot_allocator.sv
module tb_esm_slot_allocator;
  localparam int BS = 16;

`ifdef ESM_ALLOC_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          alloc_valid = 1'b0;
  logic          alloc_ready;
  logic [3:0]    alloc_index;
  logic          rel_valid = 1'b0;
  logic [3:0]    rel_index = '0;
  logic          flush = 1'b0;
  logic [4:0]    free_count;
  logic [BS-1:0] occupied;
  logic          rel_err;

  int vectors = 0;
  int errors  = 0;

  // Reference model: free list as a queue, occupancy as a bit array, pending error flag.
  int          m_q[$];
  bit [BS-1:0] m_occ;
  bit          m_err;

  esm_slot_allocator #(.bs(BS)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .alloc_valid_i (alloc_valid),
    .alloc_ready_o (alloc_ready),
    .alloc_index_o (alloc_index),
    .rel_valid_i   (rel_valid),
    .rel_index_i   (rel_index),
    .flush_i       (flush),
    .free_count_o  (free_count),
    .occupied_o    (occupied),
    .rel_err_o     (rel_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < BS; i++) m_q.push_back(i);
    m_occ = '0;
    m_err = 1'b0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    bit legal;
    int g;
    if (flush) begin
      model_reset();
    end else begin
      legal = rel_valid && m_occ[rel_index];
      if (BYPASS && m_q.size() == 0 && legal && alloc_valid) begin
        // slot passes straight to dispatch; nothing changes
      end else begin
        if (alloc_valid && m_q.size() != 0) begin
          g = m_q.pop_front();
          m_occ[g] = 1'b1;
        end
        if (legal) begin
          m_q.push_back(int'(rel_index));
          m_occ[rel_index] = 1'b0;
        end
      end
      m_err = rel_valid && !legal;
    end
  endtask

  task automatic drive(input bit av, input bit rv, input int ri, input bit fl);
    alloc_valid = av;
    rel_valid   = rv;
    rel_index   = 4'(ri);
    flush       = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 0);
    model_reset();
    vectors++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", alloc_ready); end
    vectors++; if (alloc_index !== 4'd0) begin errors++; $display("FAIL reset_index got %0d want 0", alloc_index); end
    vectors++; if (free_count !== 5'd16) begin errors++; $display("FAIL reset_count got %0d want 16", free_count); end
    vectors++; if (occupied !== 16'h0) begin errors++; $display("FAIL reset_occ got %h want 0", occupied); end
    vectors++; if (rel_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", rel_err); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fill();
    for (int i = 0; i < BS; i++) begin
      drive(1, 0, 0, 0);
      vectors++; if (alloc_index !== 4'(i)) begin errors++; $display("FAIL fill_index[%0d] got %0d want %0d", i, alloc_index, i); end
      vectors++; if (free_count !== 5'(BS - i)) begin errors++; $display("FAIL fill_count[%0d] got %0d want %0d", i, free_count, BS - i); end
      tick();
    end
    drive(1, 0, 0, 0);
    vectors++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %b want 0", alloc_ready); end
    vectors++; if (free_count !== 5'd0) begin errors++; $display("FAIL fill_count_end got %0d want 0", free_count); end
    vectors++; if (occupied !== 16'hFFFF) begin errors++; $display("FAIL fill_occ got %h want ffff", occupied); end
    tick();
  endtask

  task automatic test_release_order();
    drive(0, 1, 5, 0); tick();
    drive(0, 1, 9, 0); tick();
    drive(0, 0, 0, 0);
    vectors++; if (free_count !== 5'd2) begin errors++; $display("FAIL order_count got %0d want 2", free_count); end
    vectors++; if (rel_err !== 1'b0) begin errors++; $display("FAIL order_err got %b want 0", rel_err); end
    drive(1, 0, 0, 0);
    vectors++; if (alloc_index !== 4'd5) begin errors++; $display("FAIL order_first got %0d want 5", alloc_index); end
    tick();
    vectors++; if (alloc_index !== 4'd9) begin errors++; $display("FAIL order_second got %0d want 9", alloc_index); end
    tick();
    vectors++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL order_ready got %b want 0", alloc_ready); end
  endtask

  task automatic test_double_free();
    drive(0, 0, 0, 1); tick();
    drive(0, 0, 0, 0);
    vectors++; if (free_count !== 5'd16) begin errors++; $display("FAIL flush_pre_count got %0d want 16", free_count); end
    for (int i = 0; i < 4; i++) begin drive(1, 0, 0, 0); tick(); end
    drive(0, 1, 2, 0); tick();
    drive(0, 0, 0, 0);
    vectors++; if (rel_err !== 1'b0) begin errors++; $display("FAIL dbl_first_err got %b want 0", rel_err); end
    drive(0, 1, 2, 0); tick();
    drive(0, 0, 0, 0);
    vectors++; if (rel_err !== 1'b1) begin errors++; $display("FAIL dbl_err got %b want 1", rel_err); end
    vectors++; if (free_count !== 5'd13) begin errors++; $display("FAIL dbl_count got %0d want 13", free_count); end
    tick();
    vectors++; if (rel_err !== 1'b0) begin errors++; $display("FAIL dbl_err_clear got %b want 0", rel_err); end
  endtask

  task automatic test_simultaneous();
    // free list now 4..15,2; take nine to leave 13,14,15,2
    for (int i = 0; i < 9; i++) begin drive(1, 0, 0, 0); tick(); end
    drive(1, 1, 1, 0);
    vectors++; if (free_count !== 5'd4) begin errors++; $display("FAIL simul_pre_count got %0d want 4", free_count); end
    vectors++; if (alloc_index !== 4'd13) begin errors++; $display("FAIL simul_index got %0d want 13", alloc_index); end
    tick();
    drive(0, 0, 0, 0);
    vectors++; if (free_count !== 5'd4) begin errors++; $display("FAIL simul_count got %0d want 4", free_count); end
    vectors++; if (occupied[1] !== 1'b0) begin errors++; $display("FAIL simul_occ1 got %b want 0", occupied[1]); end
    vectors++; if (occupied[13] !== 1'b1) begin errors++; $display("FAIL simul_occ13 got %b want 1", occupied[13]); end
    vectors++; if (rel_err !== 1'b0) begin errors++; $display("FAIL simul_err got %b want 0", rel_err); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin drive(1, 0, 0, 0); tick(); end
    drive(0, 0, 0, 0);
    vectors++; if (free_count !== 5'd0) begin errors++; $display("FAIL flush_full_count got %0d want 0", free_count); end
    drive(0, 1, 5, 1); tick();
    drive(0, 0, 0, 0);
    vectors++; if (free_count !== 5'd16) begin errors++; $display("FAIL flush_count got %0d want 16", free_count); end
    vectors++; if (occupied !== 16'h0) begin errors++; $display("FAIL flush_occ got %h want 0", occupied); end
    vectors++; if (alloc_index !== 4'd0) begin errors++; $display("FAIL flush_index got %0d want 0", alloc_index); end
    vectors++; if (rel_err !== 1'b0) begin errors++; $display("FAIL flush_err got %b want 0", rel_err); end
  endtask

  task automatic test_empty_release();
    for (int i = 0; i < BS; i++) begin drive(1, 0, 0, 0); tick(); end
    drive(1, 1, 7, 0);
    if (BYPASS) begin
      vectors++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL byp_ready got %b want 1", alloc_ready); end
      vectors++; if (alloc_index !== 4'd7) begin errors++; $display("FAIL byp_index got %0d want 7", alloc_index); end
      tick();
      drive(0, 0, 0, 0);
      vectors++; if (free_count !== 5'd0) begin errors++; $display("FAIL byp_count got %0d want 0", free_count); end
      vectors++; if (occupied[7] !== 1'b1) begin errors++; $display("FAIL byp_occ7 got %b want 1", occupied[7]); end
    end else begin
      vectors++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL nobyp_ready got %b want 0", alloc_ready); end
      tick();
      drive(1, 0, 0, 0);
      vectors++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL nobyp_ready_next got %b want 1", alloc_ready); end
      vectors++; if (alloc_index !== 4'd7) begin errors++; $display("FAIL nobyp_index got %0d want 7", alloc_index); end
      vectors++; if (free_count !== 5'd1) begin errors++; $display("FAIL nobyp_count got %0d want 1", free_count); end
      tick();
      drive(0, 0, 0, 0);
      vectors++; if (free_count !== 5'd0) begin errors++; $display("FAIL nobyp_count_end got %0d want 0", free_count); end
    end
  endtask

  task automatic test_random();
    bit av, rv, fl, exp_ready, legal;
    int ri, n;
    int occ_list[$];
    for (int c = 0; c < 600; c++) begin
      occ_list.delete();
      for (int i = 0; i < BS; i++) if (m_occ[i]) occ_list.push_back(i);
      av = ($urandom_range(0, 3) != 0);
      rv = ($urandom_range(0, 2) != 0);
      if (occ_list.size() != 0 && $urandom_range(0, 3) != 0) begin
        n  = $urandom_range(0, occ_list.size() - 1);
        ri = occ_list[n];
      end else begin
        ri = $urandom_range(0, BS - 1);
      end
      fl = ($urandom_range(0, 63) == 0);
      drive(av, rv, ri, fl);
      legal     = rv && m_occ[ri];
      exp_ready = (m_q.size() != 0) || (BYPASS && legal);
      vectors++; if (alloc_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d] got %b want %b", c, alloc_ready, exp_ready); end
      if (m_q.size() != 0) begin
        vectors++; if (alloc_index !== 4'(m_q[0])) begin errors++; $display("FAIL rnd_index[%0d] got %0d want %0d", c, alloc_index, m_q[0]); end
      end else if (exp_ready) begin
        vectors++; if (alloc_index !== 4'(ri)) begin errors++; $display("FAIL rnd_byp_index[%0d] got %0d want %0d", c, alloc_index, ri); end
      end
      vectors++; if (free_count !== 5'(m_q.size())) begin errors++; $display("FAIL rnd_count[%0d] got %0d want %0d", c, free_count, m_q.size()); end
      vectors++; if (occupied !== m_occ) begin errors++; $display("FAIL rnd_occ[%0d] got %h want %h", c, occupied, m_occ); end
      vectors++; if (rel_err !== m_err) begin errors++; $display("FAIL rnd_err[%0d] got %b want %b", c, rel_err, m_err); end
      tick();
    end
    // asynchronous reset in the middle of traffic
    drive(1, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    vectors++; if (free_count !== 5'd16) begin errors++; $display("FAIL midrst_count got %0d want 16", free_count); end
    vectors++; if (occupied !== 16'h0) begin errors++; $display("FAIL midrst_occ got %h want 0", occupied); end
    vectors++; if (alloc_index !== 4'd0) begin errors++; $display("FAIL midrst_index got %0d want 0", alloc_index); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_release_order();
    test_double_free();
    test_simultaneous();
    test_flush();
    test_empty_release();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
